simplebus_mem_responder: RTL and testbench

//  SimpleBus slave that terminates the cache's io_out_mem port: accepts single and burst

---
 rtl/simplebus_pkg.sv | 24 ++
 rtl/simplebus_mem_array.sv | 25 ++
 rtl/simplebus_mem_responder.sv | 127 ++++++++++++
 tb/tb_simplebus_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simplebus_pkg.sv
// simplebus_pkg: SimpleBus command/response encodings, responder states and width helpers
package simplebus_pkg;

    localparam logic [3:0] CMD_READ        = 4'b0000;
    localparam logic [3:0] CMD_WRITE       = 4'b0001;
    localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
    localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
    localparam logic [3:0] CMD_PREFETCH    = 4'b0100;
    localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
    localparam logic [3:0] CMD_PROBE       = 4'b1000;

    localparam logic [3:0] RESP_READ       = 4'b0000;
    localparam logic [3:0] RESP_READ_LAST  = 4'b0110;
    localparam logic [3:0] RESP_WRITE      = 4'b0101;
    localparam logic [3:0] RESP_PROBE_MISS = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_WAIT, S_RESP} state_t;

    // Width of a beat offset within a line; at least one bit so slices stay legal
    function automatic int beat_w(input int beats);
        return beats > 1 ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/simplebus_mem_array.sv
// simplebus_mem_array: DEPTH x DATA_W RAM with one byte-masked write port and one registered read port
module simplebus_mem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W/8-1:0]      wmask,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read; contents are never cleared
    always_ff @(posedge clock) begin
        if (we)
            for (int i = 0; i < DATA_W/8; i++)
                if (wmask[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/simplebus_mem_responder.sv
// simplebus_mem_responder: SimpleBus slave backed by a word RAM, single/burst access with programmable latency
module simplebus_mem_responder
    import simplebus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int BEATS   = 8,
    parameter int LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_in_req_ready,
    input  logic                io_in_req_valid,
    input  logic [ADDR_W-1:0]   io_in_req_bits_addr,
    input  logic [2:0]          io_in_req_bits_size,
    input  logic [3:0]          io_in_req_bits_cmd,
    input  logic [DATA_W/8-1:0] io_in_req_bits_wmask,
    input  logic [DATA_W-1:0]   io_in_req_bits_wdata,
    input  logic                io_in_resp_ready,
    output logic                io_in_resp_valid,
    output logic [3:0]          io_in_resp_bits_cmd,
    output logic [DATA_W-1:0]   io_in_resp_bits_rdata,
    output logic                io_err
);

    localparam int OW = $clog2(DATA_W/8);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = beat_w(BEATS);
    localparam state_t S_GO = (LATENCY == 0) ? S_RESP : S_WAIT;

    state_t          state, state_n;
    logic [3:0]      cmd_q, cnt;
    logic [IW-1:0]   idx_q, req_idx, raddr, waddr;
    logic [BW:0]     beat;
    logic [BW-1:0]   bo_n;
    logic [DATA_W-1:0] ram_q;
    logic            err, acc, hs, last, burst_q, is_wr, known, burst_beat, over, we;
    logic            unused_bits;

    assign unused_bits = ^{io_in_req_bits_size, io_in_req_bits_addr[ADDR_W-1:OW+IW], io_in_req_bits_addr[OW-1:0]};
    assign io_err      = err;

    // Request decode, beat bookkeeping and RAM port addressing
    always_comb begin
        acc        = io_in_req_valid && io_in_req_ready;
        hs         = state == S_RESP && io_in_resp_ready;
        req_idx    = io_in_req_bits_addr[OW +: IW];
        burst_q    = cmd_q == CMD_READ_BURST;
        last       = !burst_q || beat[BW-1:0] == BW'(BEATS-1);
        is_wr      = io_in_req_bits_cmd == CMD_WRITE || io_in_req_bits_cmd == CMD_WRITE_BURST;
        known      = io_in_req_bits_cmd inside {CMD_READ, CMD_WRITE, CMD_READ_BURST, CMD_WRITE_BURST, CMD_PREFETCH, CMD_PROBE};
        burst_beat = io_in_req_bits_cmd == CMD_WRITE_BURST || io_in_req_bits_cmd == CMD_WRITE_LAST;
        over       = beat >= (BW+1)'(BEATS);
        we         = acc && (state == S_IDLE ? is_wr : burst_beat && !over);
        waddr      = state == S_IDLE ? req_idx : {idx_q[IW-1:BW], idx_q[BW-1:0] + beat[BW-1:0]};
        // Look one beat ahead on a handshake so the registered read keeps bursts back-to-back
        bo_n       = hs ? beat[BW-1:0] + BW'(1) : beat[BW-1:0];
        raddr      = state == S_IDLE ? req_idx : {idx_q[IW-1:BW], idx_q[BW-1:0] + bo_n};
    end

    simplebus_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wmask (io_in_req_bits_wmask),
        .wdata (io_in_req_bits_wdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:     if (acc) state_n = io_in_req_bits_cmd == CMD_WRITE_BURST ? S_WR_BURST : S_GO;
            S_WR_BURST: if (acc) state_n = io_in_req_bits_cmd == CMD_WRITE_LAST ? S_GO :
                                           io_in_req_bits_cmd == CMD_WRITE_BURST ? S_WR_BURST : S_IDLE;
            S_WAIT:     if (cnt <= 4'd1) state_n = S_RESP;
            default:    if (hs && last) state_n = S_IDLE;
        endcase
    end

    // Captured request, latency counter, beat counter and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_q <= '0;
            idx_q <= '0;
            beat  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            if (state == S_IDLE && acc) begin
                cmd_q <= io_in_req_bits_cmd;
                idx_q <= req_idx;
                beat  <= io_in_req_bits_cmd == CMD_WRITE_BURST ? (BW+1)'(1) : '0;
                cnt   <= 4'(LATENCY);
                if (!known) err <= 1'b1;
            end
            if (state == S_WR_BURST && acc) begin
                cnt <= 4'(LATENCY);
                if (burst_beat && !over) beat <= beat + (BW+1)'(1);
                if (!burst_beat || over) err <= 1'b1;
            end
            if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (hs) beat <= beat + (BW+1)'(1);
        end
    end

    // Handshake and response outputs; bits are zero outside a response
    always_comb begin
        io_in_req_ready       = !reset && (state == S_IDLE || state == S_WR_BURST);
        io_in_resp_valid      = state == S_RESP;
        io_in_resp_bits_cmd   = state != S_RESP ? 4'b0000 :
                                (cmd_q == CMD_READ || (burst_q && last)) ? RESP_READ_LAST :
                                burst_q ? RESP_READ :
                                cmd_q == CMD_PROBE ? RESP_PROBE_MISS : RESP_WRITE;
        io_in_resp_bits_rdata = (state == S_RESP && (cmd_q == CMD_READ || burst_q)) ? ram_q : '0;
    end

endmodule

// File: tb/tb_simplebus_mem_responder.sv
// tb_simplebus_mem_responder: directed self-checking bench for the SimpleBus memory responder
module tb_simplebus_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_req_ready;
    logic        io_in_req_valid;
    logic [31:0] io_in_req_bits_addr;
    logic [2:0]  io_in_req_bits_size;
    logic [3:0]  io_in_req_bits_cmd;
    logic [7:0]  io_in_req_bits_wmask;
    logic [63:0] io_in_req_bits_wdata;
    logic        io_in_resp_ready;
    logic        io_in_resp_valid;
    logic [3:0]  io_in_resp_bits_cmd;
    logic [63:0] io_in_resp_bits_rdata;
    logic        io_err;

    int pass = 0;
    int total = 0;

    simplebus_mem_responder dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_in_req_ready       (io_in_req_ready),
        .io_in_req_valid       (io_in_req_valid),
        .io_in_req_bits_addr   (io_in_req_bits_addr),
        .io_in_req_bits_size   (io_in_req_bits_size),
        .io_in_req_bits_cmd    (io_in_req_bits_cmd),
        .io_in_req_bits_wmask  (io_in_req_bits_wmask),
        .io_in_req_bits_wdata  (io_in_req_bits_wdata),
        .io_in_resp_ready      (io_in_resp_ready),
        .io_in_resp_valid      (io_in_resp_valid),
        .io_in_resp_bits_cmd   (io_in_resp_bits_cmd),
        .io_in_resp_bits_rdata (io_in_resp_bits_rdata),
        .io_err                (io_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request beat for a single cycle; returns one cycle after the accepting edge
    task automatic req(input logic [3:0] c, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        io_in_req_valid      = 1'b1;
        io_in_req_bits_cmd   = c;
        io_in_req_bits_addr  = a;
        io_in_req_bits_wdata = d;
        io_in_req_bits_wmask = m;
        io_in_req_bits_size  = 3'd3;
        step();
        io_in_req_valid = 1'b0;
    endtask

    // Cycles waited until resp_valid (0 = already valid); -1 when the bound expires
    task automatic wait_resp(output int n);
        n = 0;
        while (!io_in_resp_valid && n < 40) begin
            step();
            n++;
        end
        if (!io_in_resp_valid) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (io_in_req_ready !== 1'b0) $display("FAIL rst_req_ready_in_reset got %b exp 0", io_in_req_ready); else pass++;
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", io_in_resp_valid); else pass++;
        reset = 1'b0;
        #1;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL rst_req_ready_after got %b exp 1", io_in_req_ready); else pass++;
        total++; if (io_err !== 1'b0) $display("FAIL rst_err got %b exp 0", io_err); else pass++;
        total++; if (io_in_resp_bits_cmd !== 4'h0) $display("FAIL rst_resp_cmd got %h exp 0", io_in_resp_bits_cmd); else pass++;
        total++; if (io_in_resp_bits_rdata !== 64'h0) $display("FAIL rst_resp_rdata got %h exp 0", io_in_resp_bits_rdata); else pass++;
    endtask

    task automatic test_write_read();
        int n;
        req(4'b0001, 32'h8000_0008, 64'h1122334455667788, 8'hFF);
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL wr_latency got %0d exp 2", n); else pass++;
        total++; if (io_in_resp_bits_cmd !== 4'b0101) $display("FAIL wr_resp_cmd got %h exp 5", io_in_resp_bits_cmd); else pass++;
        total++; if (io_in_resp_bits_rdata !== 64'h0) $display("FAIL wr_resp_rdata got %h exp 0", io_in_resp_bits_rdata); else pass++;
        step();
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL wr_idle_ready got %b exp 1", io_in_req_ready); else pass++;
        req(4'b0000, 32'h8000_0008, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL rd_latency got %0d exp 2", n); else pass++;
        total++; if (io_in_resp_bits_cmd !== 4'b0110) $display("FAIL rd_resp_cmd got %h exp 6", io_in_resp_bits_cmd); else pass++;
        total++; if (io_in_resp_bits_rdata !== 64'h1122334455667788) $display("FAIL rd_rdata got %h exp 1122334455667788", io_in_resp_bits_rdata); else pass++;
        step();
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL rd_single_beat got %b exp 0", io_in_resp_valid); else pass++;
    endtask

    task automatic test_burst();
        int n;
        logic [63:0] exp_d;
        req(4'b0011, 32'h8000_0040, 64'd0, 8'hFF);
        for (int k = 1; k < 8; k++) begin
            total++; if (io_in_req_ready !== 1'b1) $display("FAIL wb_ready beat %0d got %b exp 1", k, io_in_req_ready); else pass++;
            req(k == 7 ? 4'b0111 : 4'b0011, 32'h0, 64'(k), 8'hFF);
        end
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL wb_latency got %0d exp 2", n); else pass++;
        total++; if (io_in_resp_bits_cmd !== 4'b0101) $display("FAIL wb_resp_cmd got %h exp 5", io_in_resp_bits_cmd); else pass++;
        step();
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL wb_one_resp got %b exp 0", io_in_resp_valid); else pass++;
        req(4'b0010, 32'h8000_0058, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL rb_latency got %0d exp 2", n); else pass++;
        for (int k = 0; k < 8; k++) begin
            exp_d = 64'((k + 3) % 8);
            total++; if (io_in_resp_valid !== 1'b1) $display("FAIL rb_valid beat %0d got %b exp 1", k, io_in_resp_valid); else pass++;
            total++; if (io_in_resp_bits_rdata !== exp_d) $display("FAIL rb_data beat %0d got %h exp %h", k, io_in_resp_bits_rdata, exp_d); else pass++;
            total++; if (io_in_resp_bits_cmd !== (k == 7 ? 4'b0110 : 4'b0000)) $display("FAIL rb_cmd beat %0d got %h exp %h", k, io_in_resp_bits_cmd, (k == 7 ? 4'b0110 : 4'b0000)); else pass++;
            step();
        end
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL rb_end_valid got %b exp 0", io_in_resp_valid); else pass++;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL rb_end_ready got %b exp 1", io_in_req_ready); else pass++;
    endtask

    task automatic test_stall();
        int n;
        int i = 0;
        int c = 0;
        logic [3:0] pat = 4'b1001;
        logic rr;
        req(4'b0010, 32'h8000_0040, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL st_latency got %0d exp 2", n); else pass++;
        while (i < 8 && c < 64) begin
            rr = pat[c % 4];
            io_in_resp_ready = rr;
            total++; if (io_in_resp_valid !== 1'b1) $display("FAIL st_valid cycle %0d got %b exp 1", c, io_in_resp_valid); else pass++;
            total++; if (io_in_resp_bits_rdata !== 64'(i)) $display("FAIL st_data cycle %0d got %h exp %h", c, io_in_resp_bits_rdata, 64'(i)); else pass++;
            total++; if (io_in_resp_bits_cmd !== (i == 7 ? 4'b0110 : 4'b0000)) $display("FAIL st_cmd cycle %0d got %h exp %h", c, io_in_resp_bits_cmd, (i == 7 ? 4'b0110 : 4'b0000)); else pass++;
            total++; if (io_in_req_ready !== 1'b0) $display("FAIL st_req_ready cycle %0d got %b exp 0", c, io_in_req_ready); else pass++;
            step();
            if (rr) i++;
            c++;
        end
        io_in_resp_ready = 1'b1;
        total++; if (i !== 8) $display("FAIL st_beats got %0d exp 8", i); else pass++;
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL st_end_valid got %b exp 0", io_in_resp_valid); else pass++;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL st_end_ready got %b exp 1", io_in_req_ready); else pass++;
    endtask

    task automatic test_wmask();
        int n;
        req(4'b0001, 32'h8000_0100, 64'h0, 8'hFF);
        wait_resp(n);
        step();
        req(4'b0001, 32'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        wait_resp(n);
        step();
        req(4'b0000, 32'h8000_0100, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (n !== 2) $display("FAIL wm_latency got %0d exp 2", n); else pass++;
        total++; if (io_in_resp_bits_rdata !== 64'h0000_0000_FFFF_FFFF) $display("FAIL wm_rdata got %h exp 00000000ffffffff", io_in_resp_bits_rdata); else pass++;
        step();
    endtask

    task automatic test_wr_burst_err();
        int seen = 0;
        req(4'b0011, 32'h8000_0200, 64'hAAAA, 8'hFF);
        total++; if (io_err !== 1'b0) $display("FAIL we_err_before got %b exp 0", io_err); else pass++;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL we_ready_in_burst got %b exp 1", io_in_req_ready); else pass++;
        req(4'b0000, 32'h8000_0200, 64'h0, 8'h00);
        total++; if (io_err !== 1'b1) $display("FAIL we_err got %b exp 1", io_err); else pass++;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL we_idle_ready got %b exp 1", io_in_req_ready); else pass++;
        for (int k = 0; k < 6; k++) begin
            if (io_in_resp_valid) seen++;
            step();
        end
        total++; if (seen !== 0) $display("FAIL we_no_resp got %0d exp 0", seen); else pass++;
    endtask

    task automatic test_reset_mid_burst();
        int n;
        req(4'b0010, 32'h8000_0040, 64'h0, 8'h00);
        wait_resp(n);
        step();
        step();
        step();
        total++; if (io_in_resp_bits_rdata !== 64'd3) $display("FAIL rm_beat3 got %h exp 3", io_in_resp_bits_rdata); else pass++;
        reset = 1'b1;
        step();
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL rm_valid got %b exp 0", io_in_resp_valid); else pass++;
        reset = 1'b0;
        #1;
        total++; if (io_in_req_ready !== 1'b1) $display("FAIL rm_ready got %b exp 1", io_in_req_ready); else pass++;
        total++; if (io_err !== 1'b0) $display("FAIL rm_err_cleared got %b exp 0", io_err); else pass++;
        req(4'b0000, 32'h8000_0048, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (io_in_resp_bits_rdata !== 64'd1) $display("FAIL rm_ram_line got %h exp 1", io_in_resp_bits_rdata); else pass++;
        step();
        req(4'b0000, 32'h8000_0008, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (io_in_resp_bits_rdata !== 64'h1122334455667788) $display("FAIL rm_ram_word got %h exp 1122334455667788", io_in_resp_bits_rdata); else pass++;
        step();
    endtask

    task automatic test_misc_cmds();
        int n;
        req(4'b1000, 32'h8000_0008, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (io_in_resp_bits_cmd !== 4'b1000) $display("FAIL probe_cmd got %h exp 8", io_in_resp_bits_cmd); else pass++;
        total++; if (io_in_resp_bits_rdata !== 64'h0) $display("FAIL probe_rdata got %h exp 0", io_in_resp_bits_rdata); else pass++;
        step();
        req(4'b0100, 32'h8000_0008, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (io_in_resp_bits_cmd !== 4'b0101) $display("FAIL prefetch_cmd got %h exp 5", io_in_resp_bits_cmd); else pass++;
        step();
        total++; if (io_err !== 1'b0) $display("FAIL known_no_err got %b exp 0", io_err); else pass++;
        req(4'b1111, 32'h8000_0008, 64'h0, 8'h00);
        wait_resp(n);
        total++; if (io_in_resp_bits_cmd !== 4'b0101) $display("FAIL unknown_cmd got %h exp 5", io_in_resp_bits_cmd); else pass++;
        total++; if (io_err !== 1'b1) $display("FAIL unknown_err got %b exp 1", io_err); else pass++;
        step();
        total++; if (io_in_resp_valid !== 1'b0) $display("FAIL unknown_one_resp got %b exp 0", io_in_resp_valid); else pass++;
    endtask

    initial begin
        reset                = 1'b1;
        io_in_req_valid      = 1'b0;
        io_in_req_bits_addr  = '0;
        io_in_req_bits_size  = '0;
        io_in_req_bits_cmd   = '0;
        io_in_req_bits_wmask = '0;
        io_in_req_bits_wdata = '0;
        io_in_resp_ready     = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_burst();
        test_stall();
        test_wmask();
        test_wr_burst_err();
        test_reset_mid_burst();
        test_misc_cmds();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
